// File: rtl/zap_mult_pkg.sv
// Shared types and defaults for the multiplier arbiter.
// Holds the controller state encoding and the WAIT timeout default.
package zap_mult_pkg;

   localparam int TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic [31:0] rm;
      logic [31:0] rn;
      logic [31:0] rs;
   } opnd_t;

endpackage

// File: rtl/zap_rr_arb2.sv
// Two-way round-robin grant; the requester not served last wins a tie.
// A lone request always wins.
module zap_rr_arb2 (
   input  logic [1:0] request,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = request;
      unique case (request)
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = request;
      endcase
   end

endmodule

// File: rtl/zap_mult_arbiter.sv
// Shares one multiplier between two requesters with round-robin grant,
// a WAIT timeout that aborts the multiplier, and a global flush.
module zap_mult_arbiter
   import zap_mult_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_clear,
   input  logic [1:0]  i_req_valid,
   output logic [1:0]  o_req_ready,
   input  logic [31:0] i_rm0,
   input  logic [31:0] i_rn0,
   input  logic [31:0] i_rs0,
   input  logic [31:0] i_rm1,
   input  logic [31:0] i_rn1,
   input  logic [31:0] i_rs1,
   output logic [1:0]  o_rsp_valid,
   input  logic [1:0]  i_rsp_ready,
   output logic [31:0] o_rsp_rd,
   output logic        o_rsp_err,
   output logic        o_mul_start,
   output logic        o_mul_clear,
   output logic [31:0] o_mul_rm,
   output logic [31:0] o_mul_rn,
   output logic [31:0] o_mul_rs,
   input  logic [31:0] i_mul_rd,
   input  logic        i_mul_busy,
   output logic        o_busy
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state;
   state_t        state_nx;
   opnd_t         opnd;
   logic          owner;
   logic          last;
   logic [31:0]   rsp_rd;
   logic          rsp_err;
   logic [CW-1:0] cnt;
   logic [1:0]    grant;
   logic [1:0]    req_ready;
   logic          mul_start;
   logic          mul_clear;
   logic          tmo_hit;

   zap_rr_arb2 u_arb (
      .request (i_req_valid),
      .last    (last),
      .grant   (grant)
   );

   assign tmo_hit = i_mul_busy && (cnt == CNT_LAST);

   always_comb begin
      state_nx  = state;
      req_ready = 2'b00;
      mul_start = 1'b0;
      mul_clear = 1'b0;
      if (i_clear) begin
         state_nx  = ST_IDLE;
         mul_clear = 1'b1;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (|i_req_valid && !i_mul_busy) begin
                  req_ready = grant;
                  state_nx  = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               mul_start = 1'b1;
               state_nx  = ST_WAIT;
            end
            ST_WAIT: begin
               if (!i_mul_busy) begin
                  state_nx = ST_RESP;
               end else if (tmo_hit) begin
                  mul_clear = 1'b1;
                  state_nx  = ST_RESP;
               end
            end
            ST_RESP: begin
               if (i_rsp_ready[owner]) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state   <= ST_IDLE;
         opnd    <= '0;
         owner   <= 1'b0;
         last    <= 1'b1;
         rsp_rd  <= '0;
         rsp_err <= 1'b0;
         cnt     <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && state_nx == ST_ISSUE) begin
            owner <= grant[1];
            opnd  <= grant[1] ? opnd_t'({i_rm1, i_rn1, i_rs1})
                              : opnd_t'({i_rm0, i_rn0, i_rs0});
         end
         if (state == ST_ISSUE) begin
            cnt <= '0;
         end else if (state == ST_WAIT && !i_clear) begin
            if (!i_mul_busy) begin
               rsp_rd  <= i_mul_rd;
               rsp_err <= 1'b0;
            end else if (tmo_hit) begin
               rsp_rd  <= '0;
               rsp_err <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
         // a flushed response must not move the fairness pointer
         if (state == ST_RESP && !i_clear && i_rsp_ready[owner])
            last <= owner;
      end
   end

   assign o_req_ready = req_ready;
   assign o_mul_start = mul_start;
   assign o_mul_clear = mul_clear;
   assign o_mul_rm    = opnd.rm;
   assign o_mul_rn    = opnd.rn;
   assign o_mul_rs    = opnd.rs;
   assign o_rsp_rd    = rsp_rd;
   assign o_rsp_err   = rsp_err;
   assign o_busy      = (state != ST_IDLE);
   assign o_rsp_valid = (state == ST_RESP && !i_clear)
                      ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_zap_mult_arbiter.sv
// Scoreboard bench for zap_mult_arbiter: directed scenarios followed
// by randomized traffic, checked against a behavioural reference.
module tb_zap_mult_arbiter;

   localparam int TO  = 15;
   localparam int LAT = 7;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic [1:0]  req_v = 2'b00;
   logic [1:0]  req_r;
   logic [1:0]  rsp_v;
   logic [1:0]  rsp_r = 2'b11;
   logic [31:0] rm [2];
   logic [31:0] rn [2];
   logic [31:0] rs [2];
   logic [31:0] rsp_rd;
   logic        rsp_err;
   logic        mul_start, mul_clear, busy;
   logic [31:0] mul_rm, mul_rn, mul_rs, mul_rd;
   logic        mul_busy;

   always #5 clk = ~clk;

   zap_mult_arbiter #(.TIMEOUT(TO)) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_clear     (clr),
      .i_req_valid (req_v),
      .o_req_ready (req_r),
      .i_rm0       (rm[0]),
      .i_rn0       (rn[0]),
      .i_rs0       (rs[0]),
      .i_rm1       (rm[1]),
      .i_rn1       (rn[1]),
      .i_rs1       (rs[1]),
      .o_rsp_valid (rsp_v),
      .i_rsp_ready (rsp_r),
      .o_rsp_rd    (rsp_rd),
      .o_rsp_err   (rsp_err),
      .o_mul_start (mul_start),
      .o_mul_clear (mul_clear),
      .o_mul_rm    (mul_rm),
      .o_mul_rn    (mul_rn),
      .o_mul_rs    (mul_rs),
      .i_mul_rd    (mul_rd),
      .i_mul_busy  (mul_busy),
      .o_busy      (busy)
   );

   // multiplier model: busy for 5 cycles after start, then result valid
   int          bcnt;
   logic        stuck = 1'b0;
   logic [31:0] mres;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt <= 0;
         mres <= '0;
      end else if (mul_clear) begin
         bcnt <= 0;
      end else if (mul_start) begin
         bcnt <= 5;
         mres <= mul_rm * mul_rs + mul_rn;
      end else if (bcnt > 0) begin
         bcnt <= bcnt - 1;
      end
   end
   assign mul_busy = stuck || (bcnt != 0);
   assign mul_rd   = mul_busy ? 32'hDEAD_BEEF : mres;

   int checks = 0;
   int errors = 0;

   task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [1:0] exp_grant(logic [1:0] v, int last);
      if (v == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
      return v;
   endfunction

   typedef struct {
      int          owner;
      logic [31:0] rd;
      logic        err;
      int          gedge;
      logic [31:0] rm, rn, rs;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   int          glog[$];
   int          cyc = 0;
   int          last_m = 1;
   bit          in_flight = 0;
   bit          rsp_seen = 0;
   bit          clr_pend = 0;
   bit          tmo_mode = 0;
   int          starts = 0;
   int          clrs = 0;
   logic [1:0]  hs = 2'b00;
   logic [34:0] snap;
   logic [31:0] last_rd = '0;
   logic        last_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         in_flight = 0;
         rsp_seen  = 0;
         clr_pend  = 0;
         last_m    = 1;
         hs        = 2'b00;
      end else begin
         chk("busy", busy, in_flight);
         if (clr_pend) begin
            chk("clr_no_rsp", rsp_v, 2'b00);
            clr_pend = 0;
         end
         if (mul_clear && !clr) begin
            clrs++;
            chk("mulclr_spurious", tmo_mode, 1);
         end
         if (clr) begin
            hs = 2'b00;
            chk("clr_mulclr", mul_clear, 1);
            chk("clr_ready", req_r, 2'b00);
            chk("clr_rsp", rsp_v, 2'b00);
            if (in_flight && q.size() > 0) void'(q.pop_front());
            in_flight = 0;
            rsp_seen  = 0;
            clr_pend  = 1;
         end else begin
            hs = req_r & req_v;
            if (req_r != 2'b00) begin
               chk("grant_inflight", in_flight, 0);
               chk("grant_rr", req_r, exp_grant(req_v, last_m));
            end
            if (hs != 2'b00) begin
               e.owner = hs[1] ? 1 : 0;
               e.rm    = rm[e.owner];
               e.rn    = rn[e.owner];
               e.rs    = rs[e.owner];
               e.rd    = tmo_mode ? 32'd0 : e.rm * e.rs + e.rn;
               e.err   = tmo_mode;
               e.gedge = cyc + 1;
               q.push_back(e);
               glog.push_back(e.owner);
               in_flight = 1;
               starts = 0;
               clrs = 0;
            end
            if (mul_start) begin
               starts++;
               if (q.size() > 0)
                  chk("start_opnd", {mul_rm, mul_rn, mul_rs},
                      {q[0].rm, q[0].rn, q[0].rs});
            end else if (in_flight && starts > 0 && !rsp_seen
                         && rsp_v == 2'b00 && q.size() > 0) begin
               chk("opnd_hold", {mul_rm, mul_rn, mul_rs},
                   {q[0].rm, q[0].rn, q[0].rs});
            end
            if (rsp_v != 2'b00) begin
               if (!in_flight || q.size() == 0) begin
                  chk("rsp_unexpected", rsp_v, 2'b00);
               end else if (!rsp_seen) begin
                  chk("rsp_owner", rsp_v, 2'b01 << q[0].owner);
                  chk("rsp_rd", rsp_rd, q[0].rd);
                  chk("rsp_err", rsp_err, q[0].err);
                  chk("rsp_lat", cyc - q[0].gedge,
                      q[0].err ? TO + 1 : LAT);
                  chk("start_once", starts, 1);
                  if (q[0].err) chk("tmo_mulclr", clrs, 1);
                  rsp_seen = 1;
                  snap = {rsp_v, rsp_err, rsp_rd};
               end else begin
                  chk("rsp_hold", {rsp_v, rsp_err, rsp_rd}, snap);
               end
               if (rsp_seen && rsp_r[q[0].owner]) begin
                  last_m   = q[0].owner;
                  last_rd  = rsp_rd;
                  last_err = rsp_err;
                  void'(q.pop_front());
                  in_flight = 0;
                  rsp_seen  = 0;
               end
            end else if (rsp_seen) begin
               chk("rsp_dropped", rsp_v, snap[34:33]);
               rsp_seen = 0;
            end
         end
      end
   end

   task automatic wait_grant(int r);
      int n = 0;
      @(negedge clk);
      while (!req_r[r] && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("grant_wait", req_r[r], 1);
      @(posedge clk);
      #1 req_v[r] = 1'b0;
   endtask

   task automatic issue(int r, logic [31:0] a, logic [31:0] s,
                        logic [31:0] n);
      @(posedge clk);
      #1;
      rm[r] = a;
      rs[r] = s;
      rn[r] = n;
      req_v[r] = 1'b1;
      wait_grant(r);
   endtask

   task automatic wait_idle(int budget);
      int n = 0;
      do begin
         @(negedge clk);
         #1 n++;
      end while ((in_flight || busy) && n < budget);
      chk("idle_wait", in_flight, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: sim time %0t exceeded", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int base;
      rm = '{0, 0};
      rn = '{0, 0};
      rs = '{0, 0};
      repeat (3) @(negedge clk);
      chk("rst_ready", req_r, 2'b00);
      chk("rst_rsp_v", rsp_v, 2'b00);
      chk("rst_rsp", {rsp_err, rsp_rd}, 33'd0);
      chk("rst_mulctl", {mul_start, mul_clear}, 2'b00);
      chk("rst_opnd", {mul_rm, mul_rn, mul_rs}, 96'd0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // single request
      issue(0, 32'd3, 32'd5, 32'd7);
      wait_idle(50);
      chk("single_rd", last_rd, 32'd22);

      // reset mid-operation, then contention
      issue(0, 32'd9, 32'd9, 32'd9);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_rsp", rsp_v, 2'b00);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rm = '{32'd3, 32'h10000};
      rs = '{32'd5, 32'd2};
      rn = '{32'd7, 32'd1};
      req_v = 2'b11;
      wait_grant(0);
      wait_grant(1);
      wait_idle(60);
      chk("cont_rd", last_rd, 32'h20001);

      // round-robin with both continuously valid
      base = glog.size();
      @(posedge clk);
      #1 req_v = 2'b11;
      n = 0;
      do begin
         @(negedge clk);
         #1 n++;
      end while (glog.size() < base + 4 && n < 200);
      @(posedge clk);
      #1 req_v = 2'b00;
      wait_idle(60);
      chk("rr_count", glog.size(), base + 4);
      for (int i = 0; i < 4; i++)
         if (base + i < glog.size())
            chk("rr_order", glog[base + i], i % 2);

      // backpressure
      rsp_r = 2'b10;
      issue(0, 32'd11, 32'd13, 32'd17);
      rm[1] = 32'd2;
      rs[1] = 32'd3;
      rn[1] = 32'd4;
      req_v[1] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_v[0] && n < 50);
      chk("bp_valid", rsp_v[0], 1);
      repeat (10) begin
         @(negedge clk);
         chk("bp_nogrant", req_r, 2'b00);
         chk("bp_hold_v", rsp_v, 2'b01);
      end
      @(posedge clk);
      #1 rsp_r = 2'b11;
      @(negedge clk);
      chk("bp_hs_cycle", rsp_v, 2'b01);
      @(negedge clk);
      chk("bp_done", rsp_v[0], 0);
      wait_grant(1);
      wait_idle(60);

      // timeout with the multiplier stuck busy
      tmo_mode = 1;
      issue(1, 32'd5, 32'd6, 32'd7);
      stuck = 1'b1;
      wait_idle(100);
      chk("tmo_rd", last_rd, 32'd0);
      chk("tmo_err", last_err, 1);
      @(posedge clk);
      #1;
      stuck = 1'b0;
      tmo_mode = 0;

      // clear during WAIT
      issue(0, 32'd2, 32'd3, 32'd4);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      repeat (8) begin
         @(negedge clk);
         chk("clr_quiet", rsp_v, 2'b00);
      end
      // pointer must still favour requester 0 after the flush
      @(posedge clk);
      #1 req_v = 2'b11;
      wait_grant(0);
      req_v = 2'b00;
      wait_idle(60);

      // randomized traffic
      for (int c = 0; c < 800; c++) begin
         @(posedge clk);
         #1;
         for (int r = 0; r < 2; r++) begin
            if (hs[r] || (req_v[r] && $urandom_range(7) == 0)) begin
               req_v[r] = 1'b0;
            end else if (!req_v[r] && $urandom_range(2) == 0) begin
               req_v[r] = 1'b1;
               rm[r] = $urandom;
               rs[r] = ($urandom_range(1) == 1) ? $urandom
                                                : $urandom_range(255);
               rn[r] = $urandom;
            end
         end
         rsp_r = 2'($urandom_range(3));
      end
      @(posedge clk);
      #1;
      req_v = 2'b00;
      rsp_r = 2'b11;
      wait_idle(100);
      chk("final_queue", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
